// File: rtl/v35_int_ack_seq_if.sv
// Signal bundle between the V35 interrupt-acknowledge sequencer, the PIC,
// the core and the vector-table memory port.
interface v35_int_ack_seq_if;
  logic        ce;
  logic        int_req;
  logic [7:0]  int_vector;
  logic        int_ack;
  logic        take_irq;
  logic        reti;
  logic        fint;
  logic        busy;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        vec_valid;
  logic [7:0]  vec_num;
  logic [15:0] new_ip;
  logic [15:0] new_cs;

  modport master (
    input  ce, int_req, int_vector, take_irq, reti, mem_ack, mem_rdata,
    output int_ack, fint, busy, mem_req, mem_addr, vec_valid, vec_num, new_ip, new_cs
  );

  modport slave (
    output ce, int_req, int_vector, take_irq, reti, mem_ack, mem_rdata,
    input  int_ack, fint, busy, mem_req, mem_addr, vec_valid, vec_num, new_ip, new_cs
  );
endinterface

// File: rtl/v35_int_ack_seq.sv
// V35 interrupt-acknowledge sequencer: two-pulse PIC handshake, vector capture,
// IP/CS fetch from the vector table, and RETI-driven end-of-interrupt pulses.
module v35_int_ack_seq (
  input logic               clk,
  input logic               reset,
  v35_int_ack_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, ACK1_HI, ACK1_LO, ACK2_HI, ACK2_LO, RD_IP, RD_CS, DONE
  } state_t;

  state_t      state;
  logic        phase;
  logic        int_ack;
  logic        fint;
  logic        busy;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        vec_valid;
  logic [7:0]  vec_num;
  logic [15:0] new_ip;
  logic [15:0] new_cs;

  // Each vector occupies 4 bytes at vec*4: IP word first, CS word at +2.
  // Built by concatenation so nothing can carry past bit 9.
  function automatic logic [19:0] vec_addr(input logic [7:0] vec, input logic cs_word);
    vec_addr = {10'b0, vec, cs_word, 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 1'b0;
      int_ack   <= 1'b0;
      fint      <= 1'b0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      vec_valid <= 1'b0;
      vec_num   <= '0;
      new_ip    <= '0;
      new_cs    <= '0;
    end else if (bus.ce) begin
      fint <= bus.reti;
      case (state)
        IDLE: begin
          if (bus.int_req && bus.take_irq) begin
            state   <= ACK1_HI;
            phase   <= 1'b0;
            int_ack <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ACK1_HI: begin
          phase <= ~phase;
          if (phase) begin
            state   <= ACK1_LO;
            int_ack <= 1'b0;
          end
        end
        ACK1_LO: begin
          phase <= ~phase;
          if (phase) begin
            // PIC has presented the vector since the first ack edge.
            state   <= ACK2_HI;
            int_ack <= 1'b1;
            vec_num <= bus.int_vector;
          end
        end
        ACK2_HI: begin
          phase <= ~phase;
          if (phase) begin
            state   <= ACK2_LO;
            int_ack <= 1'b0;
          end
        end
        ACK2_LO: begin
          phase <= ~phase;
          if (phase) begin
            state    <= RD_IP;
            mem_req  <= 1'b1;
            mem_addr <= vec_addr(vec_num, 1'b0);
          end
        end
        RD_IP: begin
          if (bus.mem_ack) begin
            state    <= RD_CS;
            new_ip   <= bus.mem_rdata;
            mem_addr <= vec_addr(vec_num, 1'b1);
          end
        end
        RD_CS: begin
          if (bus.mem_ack) begin
            state     <= DONE;
            new_cs    <= bus.mem_rdata;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            vec_valid <= 1'b1;
          end
        end
        DONE: begin
          // take_irq is deliberately not looked at here; only IDLE accepts.
          state     <= IDLE;
          vec_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          phase     <= 1'b0;
          int_ack   <= 1'b0;
          busy      <= 1'b0;
          mem_req   <= 1'b0;
          mem_addr  <= '0;
          vec_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.int_ack   = int_ack;
  assign bus.fint      = fint;
  assign bus.busy      = busy;
  assign bus.mem_req   = mem_req;
  assign bus.mem_addr  = mem_addr;
  assign bus.vec_valid = vec_valid;
  assign bus.vec_num   = vec_num;
  assign bus.new_ip    = new_ip;
  assign bus.new_cs    = new_cs;

endmodule

// File: doc/v35_int_ack_seq.md
V35_INT_ACK_SEQ -- requirements
Module: v35_int_ack_seq

Interface
REQ-001 SHALL have clk, input, 1, system clock.
REQ-002 SHALL have reset, input, 1, synchronous active-high reset sampled on clk rising edge; it overrides ce.
REQ-003 SHALL have ce, input, 1, clock enable; all state advances only on cycles where ce=1.
REQ-004 SHALL have int_req, input, 1, pending-interrupt request from the PIC.
REQ-005 SHALL have int_vector, input, 8, vector number from the PIC.
REQ-006 SHALL have int_ack, output, 1, acknowledge strobe to the PIC.
REQ-007 SHALL have take_irq, input, 1, core at instruction boundary and permitted to take an interrupt.
REQ-008 SHALL have reti, input, 1, core executing a RETI instruction.
REQ-009 SHALL have fint, output, 1, end-of-interrupt pulse to the PIC.
REQ-010 SHALL have busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have mem_req, output, 1, vector-table read request.
REQ-012 SHALL have mem_addr, output, 20, physical read address.
REQ-013 SHALL have mem_ack, input, 1, read complete; mem_rdata valid in the same cycle.
REQ-014 SHALL have mem_rdata, input, 16, read data.
REQ-015 SHALL have vec_valid, output, 1, one-ce-cycle pulse when new_ip and new_cs are ready.
REQ-016 SHALL have vec_num, output, 8, latched vector number.
REQ-017 SHALL have new_ip, output, 16, handler offset.
REQ-018 SHALL have new_cs, output, 16, handler segment.

Function
REQ-019 SHALL implement states IDLE, ACK1_HI, ACK1_LO, ACK2_HI, ACK2_LO, RD_IP, RD_CS and DONE, with a 1-bit phase counter.
REQ-020 In IDLE, on a ce cycle with int_req=1 and take_irq=1, SHALL go to ACK1_HI with the phase counter cleared; if either input is 0, SHALL stay in IDLE.
REQ-021 SHALL drive int_ack=1 exactly in ACK1_HI and ACK2_HI, and int_ack=0 in all other states.
REQ-022 Each ACKx state SHALL last exactly 2 ce cycles, using the phase counter, then advance in order: ACK1_HI -> ACK1_LO -> ACK2_HI -> ACK2_LO -> RD_IP.
REQ-023 This timing gives the PIC two distinct int_ack rising edges, each held for 2 ce cycles.
REQ-024 SHALL capture int_vector into vec_num on the last ce cycle of ACK1_LO, which is after the PIC has registered the vector on the first edge.
REQ-025 Once it leaves IDLE, the sequence SHALL run to completion regardless of int_req or take_irq.
REQ-026 In RD_IP, SHALL hold mem_req=1 and mem_addr = {10'b0, vec_num, 2'b00}.
REQ-027 In RD_IP, on a ce cycle with mem_ack=1, SHALL load new_ip from mem_rdata and go to RD_CS.
REQ-028 In RD_CS, SHALL hold mem_req=1 and mem_addr = {10'b0, vec_num, 2'b10}.
REQ-029 In RD_CS, on a ce cycle with mem_ack=1, SHALL load new_cs from mem_rdata and go to DONE.
REQ-030 mem_req SHALL stay asserted, with a stable address, for any number of wait cycles.
REQ-031 mem_ack SHALL be ignored outside RD_IP and RD_CS.
REQ-032 mem_req SHALL be 0 in every state other than RD_IP and RD_CS.
REQ-033 mem_addr SHALL be 0 in every state other than RD_IP and RD_CS.
REQ-034 DONE SHALL assert vec_valid for exactly one ce cycle, then return to IDLE.
REQ-035 new_ip, new_cs and vec_num SHALL hold their values until the next sequence overwrites them.
REQ-036 Address arithmetic SHALL be 20-bit with no carry beyond bit 9; the vector table is 00000h-003FFh.
REQ-037 On a ce cycle with reti=1, SHALL assert fint=1 on the next ce cycle, for one ce cycle, independent of state.
REQ-038 reti held high for N ce cycles SHALL give N fint pulses, one per ce cycle.
REQ-039 When reti and an active sequence coincide, both SHALL proceed independently.
REQ-040 A take_irq in the same cycle as DONE SHALL be ignored; a new sequence is accepted only from IDLE.
REQ-041 When ce=0, all outputs and state SHALL hold, and pulses SHALL stretch until the next ce cycle.

Reset
REQ-042 On reset, SHALL enter IDLE and clear the phase counter.
REQ-043 On reset, SHALL drive int_ack, fint, busy, mem_req, vec_valid = 0.
REQ-044 On reset, SHALL drive mem_addr, vec_num, new_ip, new_cs = 0.
REQ-045 Reset asserted mid-sequence, in any state including a pending mem read, SHALL abort it with no vec_valid pulse.
REQ-046 After such a reset, the module SHALL accept a new sequence from the first ce cycle following deassertion.

Verification
REQ-047 Stimulus: ce=1, int_req=1, take_irq=1, int_vector=24, mem_rdata 1234h then F000h, mem_ack on the first request cycle. Required response: int_ack pattern 1,1,0,0,1,1,0,0; reads at 00060h then 00062h; vec_valid pulse with new_ip=1234h, new_cs=F000h, vec_num=24.
REQ-048 Stimulus: int_req=1, take_irq=0 for 10 cycles, then take_irq=1. Required response: int_ack stays 0 and busy stays 0 until the cycle after take_irq=1.
REQ-049 Stimulus: ce toggling 1,0 with vector 2 and mem_ack delayed 3 ce cycles on each read. Required response: reads at 00008h and 0000Ah; mem_addr stable throughout the waits; each int_ack phase spans 2 ce cycles.
REQ-050 Stimulus: reset asserted in RD_CS, then a new request with int_vector=25. Required response: no vec_valid from the first sequence; the second sequence reads 00064h and 00066h.
REQ-051 Stimulus: reti pulsed during ACK2_HI. Required response: fint is 1 for one ce cycle; the ack sequence timing is unchanged.
REQ-052 Stimulus: int_req dropped to 0 during ACK1_LO. Required response: the sequence still completes and vec_valid is asserted.
